seq_fetch: RTL and testbench
============================

# seq_fetch

Instruction fetch controller for the Seq sequencer. It holds a 256-entry program RAM, loaded from a host port. On start, it fetches the instruction addressed by Seq's `next` output and issues it on `inst`/`inst_en`, one instruction every two cycles. It stops on a halt marker, a stop request, or a host halt, so the host never hand-feeds Seq.

## Interface
- `INST_WIDTH`, default 12: instruction width, `{opcode[3:0], operand[7:0]}`.
- `ADDR_WIDTH`, default 8: program address width; RAM depth is 2^ADDR_WIDTH.
- `CNT_WIDTH`, default 16: issued-instruction counter width.
- `HALT_OP`, default 4'hF: opcode treated as the end-of-program marker; it is never issued.

- `clock`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low.
- `load_en`, in, 1: program write strobe.
- `load_addr`, in, ADDR_WIDTH: program write address.
- `load_data`, in, INST_WIDTH: program write data.
- `start`, in, 1: begin or resume execution.
- `stop`, in, 1: request halt.
- `hold`, in, 1: stall; suppresses issue.
- `seq_next`, in, ADDR_WIDTH: Seq `next` output, used as the fetch address.
- `inst`, out, INST_WIDTH: instruction to Seq.
- `inst_en`, out, 1: instruction valid to Seq.
- `busy`, out, 1: state is FETCH or ISSUE.
- `done`, out, 1: one-cycle pulse on entry to HALT.
- `count`, out, CNT_WIDTH: number of instructions issued since the last start from IDLE or HALT.

## Operation
- States and transitions:
  - IDLE: `start` goes to FETCH.
  - FETCH: presents `seq_next` to the RAM read port, then goes to ISSUE. If a stop is pending, goes to HALT instead and the fetch is abandoned.
  - ISSUE: the RAM output register holds the fetched word.
    - Opcode == HALT_OP: goes to HALT; `inst_en` stays 0.
    - `hold`=1: remains in ISSUE.
    - Otherwise: goes to FETCH, or to HALT if a stop is pending.
  - HALT: `start` goes to FETCH.
- `inst` = RAM output register. `inst_en` = (state==ISSUE) & (opcode != HALT_OP) & ~`hold`.
- `stop` sets a sticky pending flag while busy. `start` clears it. `stop` in IDLE or HALT is ignored.
- `start` while busy is ignored. `start` from IDLE or HALT clears `count`.
- `count` increments on every edge where `inst_en`=1 and saturates at all-ones.
- Loads:
  - Writes are accepted only in IDLE or HALT; `load_en` while busy is ignored.
  - A load and a `start` in the same cycle are both accepted. The first fetch reads the new data.

## Timing
- Reset values: `inst`=0, `inst_en`=0, `busy`=0, `done`=0, `count`=0, state IDLE, stop flag clear.
- RAM contents are not reset and survive `reset`.
- Cycle sequence from a start:
  - Edge E0 samples `start`=1: state becomes FETCH.
  - Edge E1: RAM captures mem[`seq_next`]; state becomes ISSUE.
  - During E1–E2, `inst_en`=1.
  - Edge E2: Seq executes and updates `next`; the fetcher returns to FETCH.
- Throughput is 1 instruction per 2 cycles with `hold`=0.
- `hold` has a combinational path to `inst_en` only. It is sampled for state change at the edge.
- `done` rises the cycle after the edge that enters HALT and lasts exactly one cycle.
- Reset asserted mid-operation returns everything to reset values immediately. `inst_en` drops asynchronously.
- Address wrap: `seq_next`=8'hFF is a normal address; no special case.

## Structure
- Shared defines/package holds:
  - Seq opcode constants (`Seq_NOP`, `Seq_LDI`, …, HALT_OP).
  - The seq_fetch state encoding (IDLE, FETCH, ISSUE, HALT).
  - The instruction field slice positions.
- Sub-module `seq_fetch_ram`: 2^ADDR_WIDTH × INST_WIDTH single-clock RAM with a synchronous write port and a synchronous, registered read port.
- Top level: FSM, stop flag, counter, `inst_en` decode.

## Test plan
- Load mem[0]={`Seq_LDI`,8'hFA}, mem[1]={`Seq_NOP`,8'h00}, mem[2]={4'hF,8'h00}, then pulse `start`.
  - `inst`=12'h?FA issued with `inst_en` at cycle 2 and the NOP at cycle 4.
  - HALT is entered with no `inst_en` for the marker; `done` pulses; `count`=2.
- Program of 10 LDIs; assert `hold` for 3 cycles during the 2nd ISSUE.
  - `inst_en`=0 for those 3 cycles and the same `inst` is held.
  - Then issue resumes; final `count`=10.
- Pulse `stop` during FETCH of instruction 3 → HALT with `count`=2. Pulse `stop` during ISSUE of instruction 3 → instruction issues, HALT with `count`=3.
- `load_en` while busy with data 12'hFFF to the next address → write ignored; the original instruction issues. A load and `start` in the same cycle in IDLE → the newly loaded word issues first.
- Drive `seq_next` as a jump (0→8'h1A) → the next `inst` equals mem[8'h1A]. Force `count` toward all-ones (CNT_WIDTH=4, 20 instructions) → `count` saturates at 4'hF.
- Assert `reset` mid-ISSUE → `inst_en` drops the same cycle; all outputs return to reset values. After release, `start` re-executes from `seq_next` with RAM intact.

Source files
------------

// File: rtl/seq_fetch_pkg.sv
// Shared constants for the Seq fetch controller: opcodes, field widths, FSM encoding.
package seq_fetch_pkg;

    // Instruction layout: {opcode, operand}, opcode in the top bits.
    localparam int unsigned OPC_W = 4;
    localparam int unsigned OPR_W = 8;

    // Seq opcodes.
    localparam logic [OPC_W-1:0] SEQ_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] SEQ_LDI  = 4'h1;
    localparam logic [OPC_W-1:0] SEQ_ADD  = 4'h2;
    localparam logic [OPC_W-1:0] SEQ_SUB  = 4'h3;
    localparam logic [OPC_W-1:0] SEQ_JMP  = 4'h4;
    localparam logic [OPC_W-1:0] SEQ_JZ   = 4'h5;
    localparam logic [OPC_W-1:0] SEQ_OUT  = 4'h6;
    localparam logic [OPC_W-1:0] SEQ_HALT = 4'hF;

    // Fetch controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/seq_fetch_ram.sv
// Program RAM: synchronous write port, registered synchronous read port.
// Array contents are not reset; only the read register is.
module seq_fetch_ram #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    // Storage array write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read register next value: capture only when a read is requested.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Read output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/seq_fetch.sv
// Instruction fetch controller: fetches mem[seq_next] and issues it to Seq
// every two cycles until a halt opcode, a stop request or a hold-free stop.
module seq_fetch
    import seq_fetch_pkg::*;
#(
    parameter int unsigned      INST_WIDTH = 12,
    parameter int unsigned      ADDR_WIDTH = 8,
    parameter int unsigned      CNT_WIDTH  = 16,
    parameter logic [OPC_W-1:0] HALT_OP    = SEQ_HALT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [INST_WIDTH-1:0] load_data,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  hold,
    input  logic [ADDR_WIDTH-1:0] seq_next,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  inst_en,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  count
);

    fetch_state_e          state_q, state_d;
    logic                  stop_q, stop_d;
    logic                  done_q, done_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    logic                  rd_en;
    logic                  wr_en;
    logic [INST_WIDTH-1:0] rd_data;
    logic                  halt_op_c;
    logic                  stop_pend_c;
    logic                  inst_en_c;

    seq_fetch_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (INST_WIDTH)
    ) u_ram (
        .clk     (clock),
        .rst_n   (reset),
        .wr_en   (wr_en),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_en   (rd_en),
        .rd_addr (seq_next),
        .rd_data (rd_data)
    );

    // Decode of the fetched word and the effective stop (sticky flag or live request).
    assign halt_op_c   = (rd_data[INST_WIDTH-1 -: OPC_W] == HALT_OP);
    assign stop_pend_c = stop_q | stop;
    assign inst_en_c   = (state_q == ST_ISSUE) & ~halt_op_c & ~hold;

    // Next-state, stop flag, counter and done decode.
    always_comb begin
        state_d = state_q;
        stop_d  = stop_q;
        count_d = count_q;
        rd_en   = 1'b0;
        wr_en   = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                wr_en = load_en;
                if (start) begin
                    state_d = ST_FETCH;
                    stop_d  = 1'b0;
                    count_d = '0;
                end
            end
            ST_FETCH: begin
                if (stop) begin
                    stop_d = 1'b1;
                end
                if (stop_pend_c) begin
                    state_d = ST_HALT;
                end else begin
                    rd_en   = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (stop) begin
                    stop_d = 1'b1;
                end
                if (halt_op_c) begin
                    state_d = ST_HALT;
                end else if (!hold) begin
                    state_d = stop_pend_c ? ST_HALT : ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (inst_en_c && (count_q != '1)) begin
            count_d = count_q + CNT_WIDTH'(1);
        end

        done_d = (state_d == ST_HALT) && (state_q != ST_HALT);
    end

    // State and control registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign inst    = rd_data;
    assign inst_en = inst_en_c;
    assign busy    = (state_q == ST_FETCH) || (state_q == ST_ISSUE);
    assign done    = done_q;
    assign count   = count_q;

endmodule

// File: tb/tb_seq_fetch.sv
// Scoreboard bench for seq_fetch: a program-walk model fills the expected
// instruction queue and the address trace Seq would produce; a monitor pops
// and compares on every issued instruction.
module tb_seq_fetch;
    import seq_fetch_pkg::*;

    localparam int unsigned IW      = 12;
    localparam int unsigned AW      = 8;
    localparam int unsigned CW      = 4;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    logic          clock;
    logic          reset;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [IW-1:0] load_data;
    logic          start;
    logic          stop;
    logic          hold;
    logic [AW-1:0] seq_next;
    logic [IW-1:0] inst;
    logic          inst_en;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;

    logic [IW-1:0] mem_model [256];
    logic [AW-1:0] addr_arr  [64];
    logic [IW-1:0] exp_q [$];
    int            n_issued = 0;
    int            run_base = 0;
    int            n_checks = 0;
    int            n_errors = 0;

    seq_fetch #(
        .INST_WIDTH (IW),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW),
        .HALT_OP    (SEQ_HALT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .stop      (stop),
        .hold      (hold),
        .seq_next  (seq_next),
        .inst      (inst),
        .inst_en   (inst_en),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    // Seq's next address after k issued instructions of the current run.
    assign seq_next = addr_arr[6'(n_issued - run_base)];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, expected to have finished", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every issued instruction must match the scoreboard head.
    initial begin
        forever begin
            @(negedge clock);
            if (reset && inst_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_issue: got inst 0x%0h expected no issue", inst);
                end else begin
                    check("issued_inst", inst, exp_q.pop_front());
                end
                n_issued++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [IW-1:0] d, input bit accept);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en = 1'b0;
        if (accept) mem_model[a] = d;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Walk the program as Seq would: JMP redirects, others fall through,
    // the halt marker ends the run. At most max_issue instructions issue.
    task automatic build_run(input logic [AW-1:0] start_addr, input int max_issue, output int n);
        logic [AW-1:0] pc;
        logic [IW-1:0] w;
        pc = start_addr;
        n  = 0;
        run_base = n_issued;
        for (int k = 0; k < 64; k++) begin
            w = mem_model[pc];
            addr_arr[k] = pc;
            if (w[11:8] == SEQ_HALT || n >= max_issue) break;
            exp_q.push_back(w);
            n++;
            pc = (w[11:8] == SEQ_JMP) ? w[7:0] : pc + 8'd1;
        end
    endtask

    task automatic wait_issued(input int k);
        for (int i = 0; i < 100; i++) begin
            if (n_issued - run_base >= k) return;
            tick();
        end
        n_checks++;
        n_errors++;
        $display("FAIL issue_timeout: got %0d issues expected %0d", n_issued - run_base, k);
    endtask

    task automatic wait_done(input string name, input int n);
        bit seen;
        int unsigned exp_cnt;
        seen = 1'b0;
        exp_cnt = (n > int'(CNT_MAX)) ? CNT_MAX : n;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check({name, "_done"}, 32'(seen), 1);
        check({name, "_count"}, count, exp_cnt);
        check({name, "_busy"}, busy, 0);
        tick();
        check({name, "_done_pulse"}, done, 0);
        check({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int n;
        reset     = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        start     = 1'b0;
        stop      = 1'b0;
        hold      = 1'b0;
        for (int i = 0; i < 64; i++) addr_arr[i] = '0;
        for (int i = 0; i < 256; i++) mem_model[i] = 12'($urandom_range(0, 12'hEFF));

        // Reset values.
        repeat (3) tick();
        check("rst_inst", inst, 0);
        check("rst_inst_en", inst_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        @(negedge clock);
        reset = 1'b1;
        tick();

        // Load and start in the same cycle from IDLE: new word issues first.
        load(8'h61, {SEQ_HALT, 8'h00}, 1'b1);
        mem_model[8'h60] = 12'h1A5;
        build_run(8'h60, 64, n);
        load_en = 1'b1; load_addr = 8'h60; load_data = 12'h1A5; start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        wait_done("load_start", n);

        // Basic program with issue-timing check.
        load(8'h00, {SEQ_LDI, 8'hFA}, 1'b1);
        load(8'h01, {SEQ_NOP, 8'h00}, 1'b1);
        load(8'h02, {SEQ_HALT, 8'h00}, 1'b1);
        build_run(8'h00, 64, n);
        start_pulse();
        check("basic_fetch_busy", busy, 1);
        check("basic_fetch_inst_en", inst_en, 0);
        tick();
        check("basic_first_inst_en", inst_en, 1);
        check("basic_first_inst", inst, 12'h1FA);
        wait_done("basic", n);

        // Ten LDIs with a 3-cycle hold on the second issue.
        for (int i = 0; i < 10; i++) load(8'(8'h20 + i), {SEQ_LDI, 8'($urandom)}, 1'b1);
        load(8'h2A, {SEQ_HALT, 8'h00}, 1'b1);
        build_run(8'h20, 64, n);
        start_pulse();
        wait_issued(1);
        tick();
        hold = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("hold_inst_en", inst_en, 0);
            check("hold_inst", inst, mem_model[8'h21]);
            tick();
        end
        hold = 1'b0;
        #1;
        check("hold_resume", inst_en, 1);
        wait_done("hold", n);

        // Stop during FETCH of instruction 3, then during ISSUE of instruction 3.
        for (int i = 0; i < 6; i++) load(8'(8'h40 + i), {SEQ_LDI, 8'($urandom)}, 1'b1);
        load(8'h46, {SEQ_HALT, 8'h00}, 1'b1);
        build_run(8'h40, 2, n);
        start_pulse();
        wait_issued(2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done("stop_fetch", n);
        build_run(8'h40, 3, n);
        start_pulse();
        wait_issued(2);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done("stop_issue", n);

        // Load while busy is ignored.
        for (int i = 0; i < 3; i++) load(8'(8'h50 + i), {SEQ_LDI, 8'($urandom)}, 1'b1);
        load(8'h53, {SEQ_HALT, 8'h00}, 1'b1);
        build_run(8'h50, 64, n);
        start_pulse();
        load(8'h51, 12'hFFF, 1'b0);
        wait_done("load_busy", n);

        // Jumps, including through the top address.
        load(8'h00, {SEQ_JMP, 8'h1A}, 1'b1);
        load(8'h1A, {SEQ_LDI, 8'h33}, 1'b1);
        load(8'h1B, {SEQ_JMP, 8'hFE}, 1'b1);
        load(8'hFE, {SEQ_LDI, 8'h01}, 1'b1);
        load(8'hFF, {SEQ_JMP, 8'h30}, 1'b1);
        load(8'h30, {SEQ_HALT, 8'h00}, 1'b1);
        build_run(8'h00, 64, n);
        start_pulse();
        wait_done("jump", n);

        // Twenty instructions saturate the 4-bit counter.
        for (int i = 0; i < 20; i++) load(8'(8'h80 + i), {SEQ_LDI, 8'($urandom)}, 1'b1);
        load(8'h94, {SEQ_HALT, 8'h00}, 1'b1);
        build_run(8'h80, 64, n);
        start_pulse();
        wait_done("saturate", n);

        // Reset in the middle of an issue, then rerun with RAM intact.
        build_run(8'h80, 64, n);
        start_pulse();
        wait_issued(1);
        tick();
        check("pre_reset_inst_en", inst_en, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_reset_inst_en", inst_en, 0);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_inst", inst, 0);
        check("mid_reset_count", count, 0);
        check("mid_reset_done", done, 0);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b1;
        tick();
        build_run(8'h00, 64, n);
        start_pulse();
        wait_done("after_reset", n);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
